// File: rtl/axi_4_lite_mst_arb.sv
// Two-requester AXI4-Lite master arbiter: one outstanding single-beat read or write at a time.
// Define AXI_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module axi_4_lite_mst_arb #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                       M_AXI_ACLK,
    input  logic                       M_AXI_ARESET,
    input  logic [1:0]                 REQ_VALID,
    output logic [1:0]                 REQ_READY,
    input  logic [1:0]                 REQ_WE,
    input  logic [2*ADDR_W-1:0]        REQ_ADDR,
    input  logic [2*DATA_W-1:0]        REQ_WDATA,
    input  logic [2*(DATA_W/8)-1:0]    REQ_WSTRB,
    output logic [1:0]                 RSP_VALID,
    output logic [DATA_W-1:0]          RSP_RDATA,
    output logic [1:0]                 RSP_RESP,
    output logic                       M_AXI_AWVALID,
    input  logic                       M_AXI_AWREADY,
    output logic [ADDR_W-1:0]          M_AXI_AWADDR,
    output logic                       M_AXI_WVALID,
    input  logic                       M_AXI_WREADY,
    output logic [DATA_W-1:0]          M_AXI_WDATA,
    output logic [(DATA_W/8)-1:0]      M_AXI_WSTRB,
    input  logic                       M_AXI_BVALID,
    output logic                       M_AXI_BREADY,
    input  logic [1:0]                 M_AXI_BRESP,
    output logic                       M_AXI_ARVALID,
    input  logic                       M_AXI_ARREADY,
    output logic [ADDR_W-1:0]          M_AXI_ARADDR,
    input  logic                       M_AXI_RVALID,
    output logic                       M_AXI_RREADY,
    input  logic [DATA_W-1:0]          M_AXI_RDATA,
    input  logic [1:0]                 M_AXI_RRESP
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_REQ  = 3'd1,
        S_WR_RESP = 3'd2,
        S_RD_REQ  = 3'd3,
        S_RD_RESP = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic                gnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic                aw_pend_q;
    logic                w_pend_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [1:0]          resp_q;
    logic                sel_s;
    logic                req_any_s;
    logic                accept_s;

`ifdef AXI_ARB_RR_EN
    logic                last_q;

    // Last-grant pointer; reset to 1 so requester 0 wins the first contest.
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            last_q <= 1'b1;
        end else if (accept_s) begin
            last_q <= sel_s;
        end else begin
            last_q <= last_q;
        end
    end
`endif

    // Requester selection for the current IDLE cycle.
    always_comb begin
        req_any_s = |REQ_VALID;
        accept_s  = (state_q == S_IDLE) && req_any_s && !M_AXI_ARESET;
`ifdef AXI_ARB_RR_EN
        if (REQ_VALID == 2'b11) begin
            sel_s = ~last_q;
        end else if (REQ_VALID[0]) begin
            sel_s = 1'b0;
        end else begin
            sel_s = 1'b1;
        end
`else
        if (REQ_VALID[0]) begin
            sel_s = 1'b0;
        end else begin
            sel_s = 1'b1;
        end
`endif
    end

    // FSM state register.
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; a write leaves WR_REQ once both AW and W have completed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d = REQ_WE[sel_s] ? S_WR_REQ : S_RD_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WR_REQ: begin
                if ((!aw_pend_q || M_AXI_AWREADY) && (!w_pend_q || M_AXI_WREADY)) begin
                    state_d = S_WR_RESP;
                end else begin
                    state_d = S_WR_REQ;
                end
            end
            S_WR_RESP: begin
                if (M_AXI_BVALID) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_WR_RESP;
                end
            end
            S_RD_REQ: begin
                if (M_AXI_ARREADY) begin
                    state_d = S_RD_RESP;
                end else begin
                    state_d = S_RD_REQ;
                end
            end
            S_RD_RESP: begin
                if (M_AXI_RVALID) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RD_RESP;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: handshake strobes decoded from the registered state.
    always_comb begin
        if (accept_s) begin
            REQ_READY = sel_s ? 2'b10 : 2'b01;
        end else begin
            REQ_READY = 2'b00;
        end
        M_AXI_AWVALID = (state_q == S_WR_REQ) && aw_pend_q;
        M_AXI_WVALID  = (state_q == S_WR_REQ) && w_pend_q;
        M_AXI_BREADY  = (state_q == S_WR_RESP);
        M_AXI_ARVALID = (state_q == S_RD_REQ);
        M_AXI_RREADY  = (state_q == S_RD_RESP);
        if (state_q == S_DONE) begin
            RSP_VALID = gnt_q ? 2'b10 : 2'b01;
        end else begin
            RSP_VALID = 2'b00;
        end
    end

    assign M_AXI_AWADDR = addr_q;
    assign M_AXI_ARADDR = addr_q;
    assign M_AXI_WDATA  = wdata_q;
    assign M_AXI_WSTRB  = wstrb_q;
    assign RSP_RDATA    = rdata_q;
    assign RSP_RESP     = resp_q;

    // Command latch, per-channel pending flags and response capture.
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            gnt_q     <= 1'b0;
            addr_q    <= {ADDR_W{1'b0}};
            wdata_q   <= {DATA_W{1'b0}};
            wstrb_q   <= {STRB_W{1'b0}};
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            rdata_q   <= {DATA_W{1'b0}};
            resp_q    <= 2'b00;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_s) begin
                        gnt_q     <= sel_s;
                        addr_q    <= sel_s ? REQ_ADDR[2*ADDR_W-1:ADDR_W] : REQ_ADDR[ADDR_W-1:0];
                        wdata_q   <= sel_s ? REQ_WDATA[2*DATA_W-1:DATA_W] : REQ_WDATA[DATA_W-1:0];
                        wstrb_q   <= sel_s ? REQ_WSTRB[2*STRB_W-1:STRB_W] : REQ_WSTRB[STRB_W-1:0];
                        aw_pend_q <= REQ_WE[sel_s];
                        w_pend_q  <= REQ_WE[sel_s];
                    end
                end
                S_WR_REQ: begin
                    if (M_AXI_AWREADY) begin
                        aw_pend_q <= 1'b0;
                    end
                    if (M_AXI_WREADY) begin
                        w_pend_q <= 1'b0;
                    end
                end
                S_WR_RESP: begin
                    if (M_AXI_BVALID) begin
                        resp_q  <= M_AXI_BRESP;
                        rdata_q <= {DATA_W{1'b0}};
                    end
                end
                S_RD_RESP: begin
                    if (M_AXI_RVALID) begin
                        resp_q  <= M_AXI_RRESP;
                        rdata_q <= M_AXI_RDATA;
                    end
                end
                default: begin
                    gnt_q <= gnt_q;
                end
            endcase
        end
    end

endmodule
